// File: rtl/srl8_pkg.sv
// Shared widths and types for the 8-bit logical shift-right unit.
package srl8_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SHAMT_W = 3;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/srl8_stage.sv
// One log-barrel stage: shifts right by DIST with zero fill when sel is set.
module srl8_stage
    import srl8_pkg::*;
#(
    parameter int unsigned DIST = 1
) (
    input  data_t d_in,
    input  logic  sel,
    output data_t d_out_c
);

    assign d_out_c = sel ? data_t'(d_in >> DIST) : d_in;

endmodule

// File: rtl/srl8.sv
// Registered 8-bit logical shift right; amounts of 8 or more produce zero.
module srl8
    import srl8_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  data_t A,
    input  data_t B,
    output data_t C
);

    data_t stage0_c;
    data_t stage1_c;
    data_t stage2_c;
    data_t shift_c;
    logic  ovf_c;

    srl8_stage #(.DIST(1)) u_stage0 (.d_in(A),        .sel(B[0]), .d_out_c(stage0_c));
    srl8_stage #(.DIST(2)) u_stage1 (.d_in(stage0_c), .sel(B[1]), .d_out_c(stage1_c));
    srl8_stage #(.DIST(4)) u_stage2 (.d_in(stage1_c), .sel(B[2]), .d_out_c(stage2_c));

    // Any upper amount bit means the whole operand shifts out, not a modulo wrap.
    assign ovf_c   = |B[DATA_W-1:SHAMT_W];
    assign shift_c = ovf_c ? '0 : stage2_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            C <= '0;
        end else begin
            C <= shift_c;
        end
    end

endmodule

// File: tb/tb_srl8.sv
// Directed-vector bench for srl8: reset, sweep, overflow, hold and mid-stream reset.
module tb_srl8;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;

    int vectors;
    int miscompares;

    srl8 dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .C  (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        A   = 8'hFF;
        B   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (C !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_edge%0d: C=%h expected=%h", i, C, 8'h00);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (C !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_release: C=%h expected=%h", C, 8'hFF);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_c [8];
        exp_c[0] = 8'b10110101;
        exp_c[1] = 8'b01011010;
        exp_c[2] = 8'b00101101;
        exp_c[3] = 8'b00010110;
        exp_c[4] = 8'b00001011;
        exp_c[5] = 8'b00000101;
        exp_c[6] = 8'b00000010;
        exp_c[7] = 8'b00000001;
        A = 8'b10110101;
        for (int b = 0; b < 8; b++) begin
            B = 8'(b);
            tick();
            vectors++;
            if (C !== exp_c[b]) begin
                miscompares++;
                $display("FAIL sweep_b%0d: C=%b expected=%b", b, C, exp_c[b]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] amts [3];
        amts[0] = 8'd8;
        amts[1] = 8'h62;
        amts[2] = 8'hFF;
        A = 8'b10110101;
        for (int i = 0; i < 3; i++) begin
            B = amts[i];
            tick();
            vectors++;
            if (C !== 8'h00) begin
                miscompares++;
                $display("FAIL overflow_b%h: C=%h expected=%h", amts[i], C, 8'h00);
            end
        end
    endtask

    task automatic test_no_sign_ext();
        A = 8'h80;
        B = 8'd1;
        tick();
        vectors++;
        if (C !== 8'h40) begin
            miscompares++;
            $display("FAIL nosignext_b1: C=%h expected=%h", C, 8'h40);
        end
        B = 8'd7;
        tick();
        vectors++;
        if (C !== 8'h01) begin
            miscompares++;
            $display("FAIL nosignext_b7: C=%h expected=%h", C, 8'h01);
        end
    endtask

    task automatic test_latency_hold();
        A = 8'hF0;
        B = 8'd1;
        tick();
        vectors++;
        if (C !== 8'h78) begin
            miscompares++;
            $display("FAIL latency_b1: C=%h expected=%h", C, 8'h78);
        end
        B = 8'd4;
        #2;
        vectors++;
        if (C !== 8'h78) begin
            miscompares++;
            $display("FAIL latency_pre_edge: C=%h expected=%h", C, 8'h78);
        end
        tick();
        vectors++;
        if (C !== 8'h0F) begin
            miscompares++;
            $display("FAIL latency_b4: C=%h expected=%h", C, 8'h0F);
        end
        // Glitch B between edges, restoring it before the next edge.
        B = 8'd7;
        #2;
        B = 8'hFF;
        #2;
        vectors++;
        if (C !== 8'h0F) begin
            miscompares++;
            $display("FAIL hold_glitch: C=%h expected=%h", C, 8'h0F);
        end
        B = 8'd4;
        tick();
        vectors++;
        if (C !== 8'h0F) begin
            miscompares++;
            $display("FAIL hold_after_glitch: C=%h expected=%h", C, 8'h0F);
        end
    endtask

    task automatic test_midstream_reset();
        A = 8'b10110101;
        B = 8'd2;
        tick();
        vectors++;
        if (C !== 8'h2D) begin
            miscompares++;
            $display("FAIL midrst_pre: C=%h expected=%h", C, 8'h2D);
        end
        rst = 1'b1;
        B   = 8'd3;
        tick();
        vectors++;
        if (C !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_clear: C=%h expected=%h", C, 8'h00);
        end
        rst = 1'b0;
        B   = 8'd4;
        tick();
        vectors++;
        if (C !== 8'h0B) begin
            miscompares++;
            $display("FAIL midrst_resume: C=%h expected=%h", C, 8'h0B);
        end
        B = 8'd5;
        tick();
        vectors++;
        if (C !== 8'h05) begin
            miscompares++;
            $display("FAIL midrst_next: C=%h expected=%h", C, 8'h05);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        A           = 8'h00;
        B           = 8'h00;
        test_reset();
        test_sweep();
        test_overflow();
        test_no_sign_ext();
        test_latency_hold();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
